// File: rtl/axi_copy_master.sv
// AXI4 burst copy engine: reads up to MAX_BURST beats into a local buffer, then writes them out.
// Optional build macro AXI_COPY_ERR_ABORT_EN: stop the copy at the first non-OKAY response.
module axi_copy_master #(
  parameter int DATA_WIDTH = 256,
  parameter int ADDR_WIDTH = 32,
  parameter int STRB_WIDTH = DATA_WIDTH / 8,
  parameter int ID_WIDTH   = 8,
  parameter int MAX_BURST  = 16,
  parameter int AXI_ID     = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] src_addr,
  input  logic [ADDR_WIDTH-1:0] dst_addr,
  input  logic [15:0]           beats,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [ID_WIDTH-1:0]   m_axi_arid,
  output logic [ADDR_WIDTH-1:0] m_axi_araddr,
  output logic [7:0]            m_axi_arlen,
  output logic [2:0]            m_axi_arsize,
  output logic [1:0]            m_axi_arburst,
  output logic                  m_axi_arvalid,
  input  logic                  m_axi_arready,
  input  logic [ID_WIDTH-1:0]   m_axi_rid,
  input  logic [DATA_WIDTH-1:0] m_axi_rdata,
  input  logic [1:0]            m_axi_rresp,
  input  logic                  m_axi_rlast,
  input  logic                  m_axi_rvalid,
  output logic                  m_axi_rready,
  output logic [ID_WIDTH-1:0]   m_axi_awid,
  output logic [ADDR_WIDTH-1:0] m_axi_awaddr,
  output logic [7:0]            m_axi_awlen,
  output logic [2:0]            m_axi_awsize,
  output logic [1:0]            m_axi_awburst,
  output logic                  m_axi_awvalid,
  input  logic                  m_axi_awready,
  output logic [DATA_WIDTH-1:0] m_axi_wdata,
  output logic [STRB_WIDTH-1:0] m_axi_wstrb,
  output logic                  m_axi_wlast,
  output logic                  m_axi_wvalid,
  input  logic                  m_axi_wready,
  input  logic [ID_WIDTH-1:0]   m_axi_bid,
  input  logic [1:0]            m_axi_bresp,
  input  logic                  m_axi_bvalid,
  output logic                  m_axi_bready
);

  localparam int SIZE = $clog2(STRB_WIDTH);
  localparam int IDXW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
`ifdef AXI_COPY_ERR_ABORT_EN
  localparam bit ABORT = 1'b1;
`else
  localparam bit ABORT = 1'b0;
`endif

  typedef enum logic [2:0] {IDLE, RD_ADDR, RD_DATA, WR_ADDR, WR_DATA, WR_RESP, FIN} state_t;

  state_t                state, state_nxt;
  logic [ADDR_WIDTH-1:0] src_q, dst_q, src_nxt, dst_nxt, src_m, dst_m;
  logic [15:0]           rem_q, rem_nxt;
  logic [7:0]            len_q;
  logic [8:0]            len_beats;
  logic [IDXW-1:0]       idx_q;
  logic                  busy_q, done_q, error_q;
  logic                  rd_hs, rd_bad, rd_end, b_bad, w_last;
  logic [DATA_WIDTH-1:0] buffer [MAX_BURST];
  logic                  unused_ok;

  // Burst length limited by remaining beats, buffer depth and the 4 KB page of both addresses.
  function automatic logic [7:0] calc_len(input logic [11:0] s, input logic [11:0] d,
                                          input logic [15:0] rem);
    logic [16:0] n, bs, bd;
    n  = {1'b0, rem};
    if (n > 17'(MAX_BURST)) n = 17'(MAX_BURST);
    bs = {4'b0, 13'h1000 - {1'b0, s}} >> SIZE;
    bd = {4'b0, 13'h1000 - {1'b0, d}} >> SIZE;
    if (bs < n) n = bs;
    if (bd < n) n = bd;
    if (n == 17'd0) n = 17'd1;
    return 8'(n - 17'd1);
  endfunction

  assign src_m     = {src_addr[ADDR_WIDTH-1:SIZE], {SIZE{1'b0}}};
  assign dst_m     = {dst_addr[ADDR_WIDTH-1:SIZE], {SIZE{1'b0}}};
  assign len_beats = {1'b0, len_q} + 9'd1;
  assign src_nxt   = src_q + (ADDR_WIDTH'(len_beats) << SIZE);
  assign dst_nxt   = dst_q + (ADDR_WIDTH'(len_beats) << SIZE);
  assign rem_nxt   = rem_q - {7'b0, len_beats};

  assign rd_hs  = m_axi_rvalid && m_axi_rready;
  assign rd_bad = rd_hs && (m_axi_rresp != 2'b00);
  assign rd_end = rd_hs && (m_axi_rlast || (idx_q == len_q[IDXW-1:0]));
  assign b_bad  = m_axi_bvalid && m_axi_bready && (m_axi_bresp != 2'b00);
  assign w_last = (idx_q == len_q[IDXW-1:0]);

  assign m_axi_arid    = ID_WIDTH'(AXI_ID);
  assign m_axi_araddr  = src_q;
  assign m_axi_arlen   = len_q;
  assign m_axi_arsize  = 3'(SIZE);
  assign m_axi_arburst = 2'b01;
  assign m_axi_awid    = ID_WIDTH'(AXI_ID);
  assign m_axi_awaddr  = dst_q;
  assign m_axi_awlen   = len_q;
  assign m_axi_awsize  = 3'(SIZE);
  assign m_axi_awburst = 2'b01;
  assign busy          = busy_q;
  assign done          = done_q;
  assign error         = error_q;
  assign unused_ok     = ^{m_axi_rid, m_axi_bid, src_addr[SIZE-1:0], dst_addr[SIZE-1:0]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt     = state;
    m_axi_arvalid = 1'b0;
    m_axi_rready  = 1'b0;
    m_axi_awvalid = 1'b0;
    m_axi_wvalid  = 1'b0;
    m_axi_wlast   = 1'b0;
    m_axi_wstrb   = '0;
    m_axi_wdata   = '0;
    m_axi_bready  = 1'b0;
    case (state)
      IDLE: if (start) state_nxt = (beats == 16'd0) ? FIN : RD_ADDR;
      RD_ADDR: begin
        m_axi_arvalid = 1'b1;
        if (m_axi_arready) state_nxt = RD_DATA;
      end
      RD_DATA: begin
        m_axi_rready = 1'b1;
        // In abort mode the burst still drains to RLAST, then its write is skipped.
        if (rd_end) state_nxt = (ABORT && (error_q || rd_bad)) ? FIN : WR_ADDR;
      end
      WR_ADDR: begin
        m_axi_awvalid = 1'b1;
        if (m_axi_awready) state_nxt = WR_DATA;
      end
      WR_DATA: begin
        m_axi_wvalid = 1'b1;
        m_axi_wlast  = w_last;
        m_axi_wstrb  = '1;
        m_axi_wdata  = buffer[idx_q];
        if (m_axi_wready && w_last) state_nxt = WR_RESP;
      end
      WR_RESP: begin
        m_axi_bready = 1'b1;
        if (m_axi_bvalid)
          state_nxt = ((ABORT && b_bad) || (rem_nxt == 16'd0)) ? FIN : RD_ADDR;
      end
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      src_q   <= '0;
      dst_q   <= '0;
      rem_q   <= '0;
      len_q   <= '0;
      idx_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
    end else begin
      done_q <= (state == FIN);
      if (state == FIN) busy_q <= 1'b0;
      case (state)
        IDLE: if (start) begin
          src_q   <= src_m;
          dst_q   <= dst_m;
          rem_q   <= beats;
          len_q   <= calc_len(src_m[11:0], dst_m[11:0], beats);
          idx_q   <= '0;
          error_q <= 1'b0;
          busy_q  <= 1'b1;
        end
        RD_DATA: if (rd_hs) idx_q <= rd_end ? '0 : idx_q + 1'b1;
        WR_DATA: if (m_axi_wready) idx_q <= w_last ? '0 : idx_q + 1'b1;
        WR_RESP: if (m_axi_bvalid) begin
          src_q <= src_nxt;
          dst_q <= dst_nxt;
          rem_q <= rem_nxt;
          len_q <= calc_len(src_nxt[11:0], dst_nxt[11:0], rem_nxt);
        end
        default: ;
      endcase
      if (rd_bad || b_bad) error_q <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rd_hs) buffer[idx_q] <= m_axi_rdata;
  end

endmodule

// File: tb/tb_axi_copy_master.sv
// Scoreboard bench for axi_copy_master: behavioural AXI slave, expected AR/AW/W queues.
module tb_axi_copy_master;
  localparam int DW = 256, AW = 32, SW = 32, IW = 8, MB = 16;

  logic          clk = 1'b0, rst, start;
  logic [AW-1:0] src_addr, dst_addr;
  logic [15:0]   beats;
  logic          busy, done, error;
  logic [IW-1:0] arid, rid, awid, bid;
  logic [AW-1:0] araddr, awaddr;
  logic [7:0]    arlen, awlen;
  logic [2:0]    arsize, awsize;
  logic [1:0]    arburst, awburst, rresp, bresp;
  logic          arvalid, arready, rlast, rvalid, rready, awvalid, awready;
  logic [DW-1:0] rdata, wdata;
  logic [SW-1:0] wstrb;
  logic          wlast, wvalid, wready, bvalid, bready;

  always #5 clk = ~clk;

  axi_copy_master #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .STRB_WIDTH(SW), .ID_WIDTH(IW),
                    .MAX_BURST(MB), .AXI_ID(0)) dut (
    .clk(clk), .rst(rst), .start(start), .src_addr(src_addr), .dst_addr(dst_addr),
    .beats(beats), .busy(busy), .done(done), .error(error),
    .m_axi_arid(arid), .m_axi_araddr(araddr), .m_axi_arlen(arlen), .m_axi_arsize(arsize),
    .m_axi_arburst(arburst), .m_axi_arvalid(arvalid), .m_axi_arready(arready),
    .m_axi_rid(rid), .m_axi_rdata(rdata), .m_axi_rresp(rresp), .m_axi_rlast(rlast),
    .m_axi_rvalid(rvalid), .m_axi_rready(rready),
    .m_axi_awid(awid), .m_axi_awaddr(awaddr), .m_axi_awlen(awlen), .m_axi_awsize(awsize),
    .m_axi_awburst(awburst), .m_axi_awvalid(awvalid), .m_axi_awready(awready),
    .m_axi_wdata(wdata), .m_axi_wstrb(wstrb), .m_axi_wlast(wlast), .m_axi_wvalid(wvalid),
    .m_axi_wready(wready), .m_axi_bid(bid), .m_axi_bresp(bresp), .m_axi_bvalid(bvalid),
    .m_axi_bready(bready)
  );

`ifdef AXI_COPY_ERR_ABORT_EN
  localparam bit ABORT = 1'b1;
`else
  localparam bit ABORT = 1'b0;
`endif

  typedef struct { logic [AW-1:0] addr; logic [7:0] len; } burst_t;
  typedef struct { logic [AW-1:0] addr; logic [DW-1:0] data; } beat_t;

  burst_t exp_ar[$], exp_aw[$], rd_q[$], wr_q[$];
  beat_t  exp_w[$];
  int     checks = 0, passed = 0;
  int     r_beat, w_beat, b_pend, r_total, err_beat = -1;
  bit     stall_en = 1'b0;
  logic [AW-1:0] src_base, dst_base;

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    checks++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [DW-1:0] pat(input logic [AW-1:0] a);
    logic [DW-1:0] v;
    logic [31:0]   k;
    k = a >> 5;
    for (int i = 0; i < 8; i++) v[i*32 +: 32] = (k * 32'h9E3779B1) ^ (i * 32'h01010101);
    return v;
  endfunction

  // AXI slave: every channel decided at the falling edge; DUT outputs are register-driven.
  initial begin : slave
    logic          r_hold, b_hold, pv_ar, pv_aw, pv_w, w_mid;
    logic [AW-1:0] pv_araddr, pv_awaddr, a;
    logic [7:0]    pv_arlen, pv_awlen;
    logic [DW:0]   pv_wd;
    burst_t        b, e;
    beat_t         eb;
    {arready, rvalid, rlast, awready, wready, bvalid} = '0;
    rdata = '0; rresp = '0; bresp = '0; rid = '0; bid = '0;
    {r_hold, b_hold, pv_ar, pv_aw, pv_w, w_mid} = '0;
    r_beat = 0; w_beat = 0; b_pend = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        rd_q.delete(); wr_q.delete();
        r_beat = 0; w_beat = 0; b_pend = 0;
        {arready, rvalid, rlast, awready, wready, bvalid} = '0;
        {r_hold, b_hold, pv_ar, pv_aw, pv_w, w_mid} = '0;
        continue;
      end
      // R
      if (rd_q.size() != 0) begin
        b      = rd_q[0];
        rvalid = r_hold ? 1'b1 : (stall_en ? 1'($urandom_range(0, 1)) : 1'b1);
        a      = b.addr + r_beat * 32;
        rdata  = pat(a);
        rresp  = (r_total == err_beat) ? 2'b10 : 2'b00;
        rlast  = (r_beat == int'(b.len));
        if (rvalid && rready) begin
          exp_w.push_back('{dst_base + (a - src_base), rdata});
          r_total++;
          r_beat++;
          if (rlast) begin void'(rd_q.pop_front()); r_beat = 0; end
        end
      end else begin
        rvalid = 1'b0; rlast = 1'b0;
      end
      r_hold = rvalid && !rready;
      // AR
      arready = stall_en ? 1'($urandom_range(0, 1)) : 1'b1;
      if (pv_ar) check("ar_hold", {arvalid, araddr, arlen}, {1'b1, pv_araddr, pv_arlen});
      if (arvalid && arready) begin
        check("ar_expected", exp_ar.size() != 0, 1);
        check("ar_attr", {arsize, arburst, arid}, {3'd5, 2'b01, 8'd0});
        if (exp_ar.size() != 0) begin
          e = exp_ar.pop_front();
          check("ar_addr", araddr, e.addr);
          check("ar_len", arlen, e.len);
        end
        rd_q.push_back('{araddr, arlen});
      end
      pv_ar = arvalid && !arready; pv_araddr = araddr; pv_arlen = arlen;
      // B
      bvalid = b_hold ? 1'b1 : ((b_pend > 0) ? (stall_en ? 1'($urandom_range(0, 1)) : 1'b1) : 1'b0);
      bresp  = 2'b00;
      if (bvalid && bready) b_pend--;
      b_hold = bvalid && !bready;
      // W
      wready = stall_en ? 1'($urandom_range(0, 1)) : 1'b1;
      if (pv_w) check("w_hold", {wvalid, wlast, wdata}, {1'b1, pv_wd});
      if (w_mid) check("w_cont", wvalid, 1);
      w_mid = 1'b0;
      if (wvalid && wready) begin
        check("w_expected", wr_q.size() != 0 && exp_w.size() != 0, 1);
        if (wr_q.size() != 0) begin
          b = wr_q[0];
          a = b.addr + w_beat * 32;
          check("w_last", wlast, w_beat == int'(b.len));
          check("w_strb", wstrb, {SW{1'b1}});
          if (exp_w.size() != 0) begin
            eb = exp_w.pop_front();
            check("w_addr", a, eb.addr);
            check("w_data", wdata, eb.data);
          end
          w_beat++;
          if (w_beat > int'(b.len)) begin
            void'(wr_q.pop_front()); w_beat = 0; b_pend++;
          end else w_mid = 1'b1;
        end
      end
      pv_w = wvalid && !wready; pv_wd = {wlast, wdata};
      // AW
      awready = stall_en ? 1'($urandom_range(0, 1)) : 1'b1;
      if (pv_aw) check("aw_hold", {awvalid, awaddr, awlen}, {1'b1, pv_awaddr, pv_awlen});
      if (awvalid && awready) begin
        check("aw_expected", exp_aw.size() != 0, 1);
        if (exp_aw.size() != 0) begin
          e = exp_aw.pop_front();
          check("aw_addr", awaddr, e.addr);
          check("aw_len", awlen, e.len);
        end
        wr_q.push_back('{awaddr, awlen});
      end
      pv_aw = awvalid && !awready; pv_awaddr = awaddr; pv_awlen = awlen;
    end
  end

  task automatic run_copy(input logic [AW-1:0] src, input logic [AW-1:0] dst, input int n,
                          input bit full, input int inject);
    logic [AW-1:0] s, d;
    int rem, l, bs, bd, cyc;
    s = src & ~32'h1F; d = dst & ~32'h1F; rem = n;
    src_base = s; dst_base = d; err_beat = inject; r_total = 0;
    while (rem > 0) begin
      l  = (rem > MB) ? MB : rem;
      bs = (4096 - int'(s & 32'hFFF)) / 32;
      bd = (4096 - int'(d & 32'hFFF)) / 32;
      if (bs < l) l = bs;
      if (bd < l) l = bd;
      exp_ar.push_back('{s, 8'(l - 1)});
      if (!full) break;
      exp_aw.push_back('{d, 8'(l - 1)});
      s += l * 32; d += l * 32; rem -= l;
    end
    @(negedge clk);
    src_addr = src; dst_addr = dst; beats = 16'(n); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("busy_on", busy, 1);
    check("arvalid_on", arvalid, n != 0);
    check("err_clr", error, 0);
    cyc = 0;
    while (!done && cyc < 4000) begin @(negedge clk); cyc++; end
    if (n == 0) check("zero_done_lat", cyc, 1);
    check("done", done, 1);
    check("busy_off", busy, 0);
    @(negedge clk);
    check("done_pulse", done, 0);
    check("ar_left", exp_ar.size(), 0);
    check("aw_left", exp_aw.size(), 0);
    if (full) check("w_left", exp_w.size(), 0);
    exp_w.delete(); exp_ar.delete(); exp_aw.delete();
    err_beat = -1;
  endtask

  initial begin : main
    int cyc;
    rst = 1'b1; start = 1'b0; src_addr = '0; dst_addr = '0; beats = '0;
    repeat (3) @(negedge clk);
    check("rst_ctl", {arvalid, rready, awvalid, wvalid, bready, busy, done, error}, 0);
    check("rst_addr", {araddr, awaddr, arlen, awlen}, 0);
    check("rst_wdata", {wdata, wstrb}, 0);
    rst = 1'b0;

    run_copy(32'h100, 32'h2000, 1, 1'b1, -1);
    check("err_single", error, 0);
    run_copy(32'h0, 32'h10000, 40, 1'b1, -1);
    run_copy(32'h0FE0, 32'h8000, 4, 1'b1, -1);
    stall_en = 1'b1;
    run_copy(32'h20040, 32'h51FA0, 100, 1'b1, -1);
    stall_en = 1'b0;
    check("err_stall", error, 0);
    run_copy(32'h3000, 32'h9000, 16, !ABORT, 2);
    check("err_slverr", error, 1);
    run_copy(32'h400, 32'hA000, 0, 1'b1, -1);
    check("err_zero", error, 0);

    // reset in the middle of a read burst
    exp_ar.push_back('{32'h1000, 8'd15});
    @(negedge clk);
    src_addr = 32'h1000; dst_addr = 32'hC000; beats = 16'd20; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while (!rready && cyc < 100) begin @(negedge clk); cyc++; end
    check("rd_data_reached", rready, 1);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    check("mid_rst_ctl", {arvalid, rready, awvalid, wvalid, bready, busy, done, error}, 0);
    check("mid_rst_addr", {araddr, arlen, wdata}, 0);
    exp_w.delete(); exp_ar.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    run_copy(32'h600, 32'hB000, 3, 1'b1, -1);
    check("err_after_rst", error, 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
